// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
package loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_LEN  = 3'd0;
   localparam state_t S_DATA = 3'd1;
   localparam state_t S_WR   = 3'd2;
   localparam state_t S_ACK  = 3'd3;
   localparam state_t S_DONE = 3'd4;

   typedef logic [1:0] rx_state_t;

   localparam rx_state_t RX_IDLE  = 2'd0;
   localparam rx_state_t RX_START = 2'd1;
   localparam rx_state_t RX_DATA  = 2'd2;
   localparam rx_state_t RX_STOP  = 2'd3;

   localparam logic [7:0] ACK = 8'hAA;
   localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: synchronizes rxd, samples mid-bit, reports good bytes or framing errors.
module uart_byte_rx
   import loader_pkg::*;
#(
   parameter int CLK_PER_HALF_BIT = 434
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       rxd,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_ferr
);

   localparam int CW = $clog2(2 * CLK_PER_HALF_BIT + 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(2 * CLK_PER_HALF_BIT - 1);

   rx_state_t     rx_state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic          sync1;
   logic          sync2;
   logic          sync_prev;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1     <= 1'b1;
         sync2     <= 1'b1;
         sync_prev <= 1'b1;
         rx_state  <= RX_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_ferr   <= 1'b0;
      end else begin
         sync1     <= rxd;
         sync2     <= sync1;
         sync_prev <= sync2;
         rx_valid  <= 1'b0;
         rx_ferr   <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (sync_prev && !sync2) begin
                  rx_state <= RX_START;
                  cnt      <= '0;
               end
            end
            RX_START: begin
               // A start bit that is high again at its midpoint was only a glitch.
               if (cnt == HALF_END) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  rx_state <= sync2 ? RX_IDLE : RX_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt == BIT_END) begin
                  cnt     <= '0;
                  rx_data <= {sync2, rx_data[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) begin
                     rx_state <= RX_STOP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt == BIT_END) begin
                  cnt      <= '0;
                  rx_state <= RX_IDLE;
                  if (sync2) begin
                     rx_valid <= 1'b1;
                  end else begin
                     rx_ferr <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_loader.sv
// Loads a length-prefixed program image from the UART into memory, then acks and releases the core.
module uart_loader
   import loader_pkg::*;
#(
   parameter int          CLK_PER_HALF_BIT = 434,
   parameter logic [31:0] BASE_ADR         = 32'h0,
   parameter logic [31:0] MAX_WORDS        = 32'd16384
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        rxd,
   output logic        txd,
   output logic [31:0] mem_adr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   output logic        core_rstn,
   output logic        done,
   output logic        frame_err
);

   localparam int CW = $clog2(2 * CLK_PER_HALF_BIT + 1);
   localparam logic [CW-1:0] BIT_END = CW'(2 * CLK_PER_HALF_BIT - 1);

   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ferr;

   state_t        state;
   logic [1:0]    byte_cnt;
   logic [23:0]   word;
   logic [31:0]   full_word;
   logic [31:0]   nwords;
   logic [31:0]   idx;
   logic [7:0]    ack_byte;
   logic          ack_sent;
   logic          accept;

   logic          tx_go;
   logic          tx_busy;
   logic [8:0]    tx_shift;
   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bits;

   uart_byte_rx #(
      .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
   ) u_rx (
      .clk      (clk),
      .rstn     (rstn),
      .rxd      (rxd),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ferr  (rx_ferr)
   );

   // Bytes are only consumed while parsing; during ACK and DONE they fall on the floor.
   always_comb begin
      accept    = rx_valid && ((state == S_LEN) || (state == S_DATA));
      full_word = {rx_data, word};
      tx_go     = (state == S_ACK) && !ack_sent;
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= S_LEN;
         byte_cnt  <= '0;
         word      <= '0;
         nwords    <= '0;
         idx       <= '0;
         ack_byte  <= ACK;
         ack_sent  <= 1'b0;
         mem_we    <= 1'b0;
         mem_adr   <= BASE_ADR;
         mem_wdata <= '0;
         core_rstn <= 1'b0;
         done      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if (rx_ferr) begin
            frame_err <= 1'b1;
         end
         if (accept) begin
            byte_cnt <= byte_cnt + 1'b1;
            case (byte_cnt)
               2'd0:    word[7:0]   <= rx_data;
               2'd1:    word[15:8]  <= rx_data;
               2'd2:    word[23:16] <= rx_data;
               default: ;
            endcase
         end
         case (state)
            S_LEN: begin
               if (accept && (byte_cnt == 2'd3)) begin
                  if (full_word == 32'd0) begin
                     ack_byte <= ACK;
                     ack_sent <= 1'b0;
                     state    <= S_ACK;
                  end else if (full_word > MAX_WORDS) begin
                     ack_byte <= NAK;
                     ack_sent <= 1'b0;
                     state    <= S_ACK;
                  end else begin
                     nwords <= full_word;
                     idx    <= '0;
                     state  <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               // Strobe is registered so it is high exactly during the S_WR cycle.
               if (accept && (byte_cnt == 2'd3)) begin
                  mem_we    <= 1'b1;
                  mem_adr   <= BASE_ADR + (idx << 2);
                  mem_wdata <= full_word;
                  state     <= S_WR;
               end
            end
            S_WR: begin
               if (idx == nwords - 32'd1) begin
                  ack_byte <= ACK;
                  ack_sent <= 1'b0;
                  state    <= S_ACK;
               end else begin
                  idx   <= idx + 32'd1;
                  state <= S_DATA;
               end
            end
            S_ACK: begin
               if (!ack_sent) begin
                  ack_sent <= 1'b1;
               end else if (!tx_busy) begin
                  if (ack_byte == ACK) begin
                     state     <= S_DONE;
                     done      <= 1'b1;
                     core_rstn <= 1'b1;
                  end else begin
                     state <= S_LEN;
                  end
               end
            end
            S_DONE: ;
            default: state <= S_LEN;
         endcase
      end
   end

   // tx_shift holds data bits then the stop bit; txd already shows the start bit on load.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         txd      <= 1'b1;
         tx_busy  <= 1'b0;
         tx_shift <= '0;
         tx_cnt   <= '0;
         tx_bits  <= '0;
      end else if (tx_go) begin
         txd      <= 1'b0;
         tx_shift <= {1'b1, ack_byte};
         tx_cnt   <= '0;
         tx_bits  <= '0;
         tx_busy  <= 1'b1;
      end else if (tx_busy) begin
         if (tx_cnt == BIT_END) begin
            tx_cnt <= '0;
            if (tx_bits == 4'd9) begin
               tx_busy <= 1'b0;
               txd     <= 1'b1;
            end else begin
               txd      <= tx_shift[0];
               tx_shift <= {1'b0, tx_shift[8:1]};
               tx_bits  <= tx_bits + 1'b1;
            end
         end else begin
            tx_cnt <= tx_cnt + 1'b1;
         end
      end
   end

endmodule
